// File: rtl/code25_serializer.sv
// code25_serializer: latches a word of NDIG BCD digits and sends it as a
// 2-of-5 serial frame: start 110, digit codes MSD first, a check-digit
// code, then stop 101. out_valid/out_ready handshake on the serial side.
module code25_serializer #(
    parameter int NDIG = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4*NDIG-1:0] digits,
    input  logic              out_ready,
    output logic              out_valid,
    output logic              out_bit,
    output logic              frame_start,
    output logic              frame_end,
    output logic              busy,
    output logic              err
);

    typedef enum logic [2:0] {IDLE, START, DATA, CHK, STOP, ERR} state_t;

    localparam logic [2:0] START_PAT = 3'b110;
    localparam logic [2:0] STOP_PAT  = 3'b101;
    localparam logic [2:0] LAST_DIG  = 3'(NDIG - 1);

    state_t            state;
    logic [4*NDIG-1:0] word;
    logic [3:0]        chk;
    logic [2:0]        bit_cnt;
    logic [2:0]        dig_cnt;

    logic              digits_ok;
    logic [6:0]        sum;
    logic [6:0]        sum_mod;
    logic [3:0]        chk_in;
    logic [2:0]        nb;
    logic [2:0]        nxt_idx;
    logic [4:0]        cur_code;
    logic [4:0]        nxt_code;
    logic [4:0]        first_code;
    logic [4:0]        chk_code;
    logic              xfer;

    function automatic logic [4:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 5'b11000;
            4'd1:    enc = 5'b00011;
            4'd2:    enc = 5'b00101;
            4'd3:    enc = 5'b00110;
            4'd4:    enc = 5'b01001;
            4'd5:    enc = 5'b01010;
            4'd6:    enc = 5'b01100;
            4'd7:    enc = 5'b10001;
            4'd8:    enc = 5'b10010;
            4'd9:    enc = 5'b10100;
            default: enc = 5'b00000;
        endcase
    endfunction

    // Digit index 0 is the most significant (first sent) digit.
    function automatic logic [3:0] digit_at(input logic [4*NDIG-1:0] w, input logic [2:0] idx);
        digit_at = w[4*(NDIG-1-int'(idx)) +: 4];
    endfunction

    // Validity and check digit of the word currently offered on digits.
    always_comb begin
        digits_ok = 1'b1;
        sum       = '0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (digits[4*i +: 4] > 4'd9) digits_ok = 1'b0;
            sum = sum + 7'(digits[4*i +: 4]);
        end
        sum_mod = sum % 7'd10;
        chk_in  = (sum_mod == 7'd0) ? 4'd0 : 4'(7'd10 - sum_mod);
    end

    // Code words and counter helpers for the next bit to present.
    always_comb begin
        xfer       = out_valid & out_ready;
        nb         = bit_cnt + 3'd1;
        nxt_idx    = (dig_cnt == LAST_DIG) ? dig_cnt : dig_cnt + 3'd1;
        cur_code   = enc(digit_at(word, dig_cnt));
        nxt_code   = enc(digit_at(word, nxt_idx));
        first_code = enc(digit_at(word, 3'd0));
        chk_code   = enc(chk);
    end

    // Frame FSM; out_bit always holds the bit at the current frame position,
    // so each transfer loads the bit for the position being advanced to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            word        <= '0;
            chk         <= '0;
            bit_cnt     <= '0;
            dig_cnt     <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_bit     <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (digits_ok) begin
                            state       <= START;
                            word        <= digits;
                            chk         <= chk_in;
                            bit_cnt     <= '0;
                            dig_cnt     <= '0;
                            out_valid   <= 1'b1;
                            out_bit     <= START_PAT[2];
                            frame_start <= 1'b1;
                        end else begin
                            state <= ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                ERR: begin
                    state    <= IDLE;
                    err      <= 1'b0;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
                START: begin
                    if (xfer) begin
                        frame_start <= 1'b0;
                        if (bit_cnt == 3'd2) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            dig_cnt <= '0;
                            out_bit <= first_code[4];
                        end else begin
                            bit_cnt <= nb;
                            out_bit <= START_PAT[3'd2 - nb];
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        if (bit_cnt == 3'd4) begin
                            bit_cnt <= '0;
                            if (dig_cnt == LAST_DIG) begin
                                state   <= CHK;
                                out_bit <= chk_code[4];
                            end else begin
                                dig_cnt <= nxt_idx;
                                out_bit <= nxt_code[4];
                            end
                        end else begin
                            bit_cnt <= nb;
                            out_bit <= cur_code[3'd4 - nb];
                        end
                    end
                end
                CHK: begin
                    if (xfer) begin
                        if (bit_cnt == 3'd4) begin
                            state   <= STOP;
                            bit_cnt <= '0;
                            out_bit <= STOP_PAT[2];
                        end else begin
                            bit_cnt <= nb;
                            out_bit <= chk_code[3'd4 - nb];
                        end
                    end
                end
                STOP: begin
                    if (xfer) begin
                        if (bit_cnt == 3'd2) begin
                            state     <= IDLE;
                            bit_cnt   <= '0;
                            out_valid <= 1'b0;
                            out_bit   <= 1'b0;
                            frame_end <= 1'b0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            bit_cnt   <= nb;
                            out_bit   <= STOP_PAT[3'd2 - nb];
                            frame_end <= (nb == 3'd2);
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready    <= 1'b1;
                    out_valid   <= 1'b0;
                    out_bit     <= 1'b0;
                    frame_start <= 1'b0;
                    frame_end   <= 1'b0;
                    busy        <= 1'b0;
                    err         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_code25_serializer.sv
// Directed testbench for code25_serializer (NDIG=4, 31-bit frames).
module tb_code25_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] digits;
    logic        out_ready;
    logic        out_valid;
    logic        out_bit;
    logic        frame_start;
    logic        frame_end;
    logic        busy;
    logic        err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Captured frame data
    logic [30:0] cap_bits;
    logic [30:0] cap_fs;
    logic [30:0] cap_fe;
    int          cap_n;
    int          cap_cyc;
    int          cap_stall_bad;

    localparam logic [30:0] F1234 = 31'b110_00011_00101_00110_01001_11000_101;
    localparam logic [30:0] F9999 = 31'b110_10100_10100_10100_10100_01001_101;
    localparam logic [30:0] F0000 = 31'b110_11000_11000_11000_11000_11000_101;
    localparam logic [30:0] F5678 = 31'b110_01010_01100_10001_10010_01001_101;
    localparam logic [30:0] FS_MASK = 31'h4000_0000;
    localparam logic [30:0] FE_MASK = 31'h0000_0001;

    code25_serializer #(.NDIG(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .digits     (digits),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_bit    (out_bit),
        .frame_start(frame_start),
        .frame_end  (frame_end),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] w);
        digits   = w;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Records transfers until 31 bits are seen or the cycle budget expires.
    task automatic capture(input int stall_at, input int stall_len);
        logic held;
        bit   stalled;
        stalled       = 1'b0;
        cap_bits      = '0;
        cap_fs        = '0;
        cap_fe        = '0;
        cap_n         = 0;
        cap_cyc       = 0;
        cap_stall_bad = 0;
        while (cap_n < 31 && cap_cyc < 400) begin
            if (stall_len > 0 && cap_n == stall_at && !stalled) begin
                stalled   = 1'b1;
                out_ready = 1'b0;
                held      = out_bit;
                for (int k = 0; k < stall_len; k++) begin
                    tick();
                    cap_cyc++;
                    if (out_bit !== held || out_valid !== 1'b1) cap_stall_bad++;
                end
                out_ready = 1'b1;
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                cap_bits[30-cap_n] = out_bit;
                cap_fs[30-cap_n]   = frame_start;
                cap_fe[30-cap_n]   = frame_end;
                cap_n++;
            end
            tick();
            cap_cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        digits    = 16'h1234;
        out_ready = 1'b1;
        tick();
        tick();
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else pass_cnt++;
        total_cnt++; if (out_bit !== 1'b0) $display("FAIL reset_out_bit: got %b want 0", out_bit); else pass_cnt++;
        total_cnt++; if (frame_start !== 1'b0) $display("FAIL reset_frame_start: got %b want 0", frame_start); else pass_cnt++;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick();
        total_cnt++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL reset_no_accept: got valid=%b busy=%b want 0/0", out_valid, busy); else pass_cnt++;
    endtask

    task automatic test_nominal();
        send(16'h1234);
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL nom_first_valid: got %b want 1", out_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1 || in_ready !== 1'b0) $display("FAIL nom_busy_ready: got busy=%b ready=%b want 1/0", busy, in_ready); else pass_cnt++;
        // Word changes and an offered word during the frame must have no effect
        digits   = 16'h9876;
        in_valid = 1'b1;
        capture(0, 0);
        in_valid = 1'b0;
        total_cnt++; if (cap_n !== 31) $display("FAIL nom_timeout: got %0d bits want 31", cap_n); else pass_cnt++;
        total_cnt++; if (cap_bits !== F1234) $display("FAIL nom_bits: got %b want %b", cap_bits, F1234); else pass_cnt++;
        total_cnt++; if (cap_fs !== FS_MASK) $display("FAIL nom_frame_start: got %b want %b", cap_fs, FS_MASK); else pass_cnt++;
        total_cnt++; if (cap_fe !== FE_MASK) $display("FAIL nom_frame_end: got %b want %b", cap_fe, FE_MASK); else pass_cnt++;
        total_cnt++; if (cap_cyc !== 31) $display("FAIL nom_cycles: got %0d want 31", cap_cyc); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL nom_end_state: got ready=%b valid=%b busy=%b want 1/0/0", in_ready, out_valid, busy); else pass_cnt++;
        tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL nom_no_reaccept: got %b want 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        send(16'h9999);
        capture(0, 0);
        total_cnt++; if (cap_bits !== F9999) $display("FAIL chk9999_bits: got %b want %b", cap_bits, F9999); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b_ready: got %b want 1", in_ready); else pass_cnt++;
        // Accept the next word on the very edge in_ready is first high
        send(16'h0000);
        total_cnt++; if (out_valid !== 1'b1 || frame_start !== 1'b1) $display("FAIL b2b_accept: got valid=%b fs=%b want 1/1", out_valid, frame_start); else pass_cnt++;
        capture(0, 0);
        total_cnt++; if (cap_bits !== F0000) $display("FAIL chk0000_bits: got %b want %b", cap_bits, F0000); else pass_cnt++;
        total_cnt++; if (cap_cyc !== 31) $display("FAIL chk0000_cycles: got %0d want 31", cap_cyc); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        send(16'h1234);
        capture(8, 3);
        total_cnt++; if (cap_stall_bad !== 0) $display("FAIL bp_stable: got %0d unstable cycles want 0", cap_stall_bad); else pass_cnt++;
        total_cnt++; if (cap_bits !== F1234) $display("FAIL bp_bits: got %b want %b", cap_bits, F1234); else pass_cnt++;
        total_cnt++; if (cap_fe !== FE_MASK) $display("FAIL bp_frame_end: got %b want %b", cap_fe, FE_MASK); else pass_cnt++;
        total_cnt++; if (cap_cyc !== 34) $display("FAIL bp_cycles: got %0d want 34", cap_cyc); else pass_cnt++;
    endtask

    task automatic test_invalid();
        send(16'h12A4);
        total_cnt++; if (err !== 1'b1) $display("FAIL inv_err: got %b want 1", err); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) $display("FAIL inv_state: got valid=%b ready=%b busy=%b want 0/0/1", out_valid, in_ready, busy); else pass_cnt++;
        tick();
        total_cnt++; if (err !== 1'b0) $display("FAIL inv_err_pulse: got %b want 0", err); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL inv_recover: got ready=%b valid=%b want 1/0", in_ready, out_valid); else pass_cnt++;
    endtask

    task automatic test_midframe_reset();
        send(16'h1234);
        for (int k = 0; k < 10; k++) tick();
        total_cnt++; if (out_bit !== F1234[20]) $display("FAIL mid_bit10: got %b want %b", out_bit, F1234[20]); else pass_cnt++;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL mid_reset_state: got ready=%b valid=%b busy=%b want 1/0/0", in_ready, out_valid, busy); else pass_cnt++;
        total_cnt++; if (out_bit !== 1'b0 || frame_start !== 1'b0 || frame_end !== 1'b0) $display("FAIL mid_reset_outs: got bit=%b fs=%b fe=%b want 0/0/0", out_bit, frame_start, frame_end); else pass_cnt++;
        send(16'h5678);
        capture(0, 0);
        total_cnt++; if (cap_bits !== F5678) $display("FAIL mid_fresh_bits: got %b want %b", cap_bits, F5678); else pass_cnt++;
        total_cnt++; if (cap_fs !== FS_MASK) $display("FAIL mid_fresh_fs: got %b want %b", cap_fs, FS_MASK); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_back_to_back();
        test_backpressure();
        test_invalid();
        test_midframe_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
